md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS32 pipeline.
- Consumes operands and control from the ID/EX pipeline register and holds the architectural HI/LO registers.
- Drives busy to the hazard unit, which stalls IF/ID and ID/EX (deasserts their en) while any mult/div/mfhi/mflo instruction waits on this unit.

Parameters:
- MUL_CYCLES, 5, cycles from accepted MULT/MULTU to HI/LO update.
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU to HI/LO update.

Ports:
- clk  input  1  pipeline clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  issue strobe; op/a/b valid this cycle.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved.
- a  input  32  rs operand.
- b  input  32  rt operand.
- rd_hi  input  1  read select: 1=HI, 0=LO.
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.
- hilo_out  output  32  rd_hi ? hi : lo (combinational; mfhi/mflo path).

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, busy=0, hi=0, lo=0, staging regs=0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE, MUL_RUN, DIV_RUN.
- IDLE:
  - start & op∈{0,1}: latch product into staging, counter=MUL_CYCLES-1, go to MUL_RUN.
  - start & op∈{2,3}: latch quotient/remainder into staging, counter=DIV_CYCLES-1, go to DIV_RUN.
  - start & op=4: hi<=a at the same edge. start & op=5: lo<=a at the same edge. Stay IDLE, busy stays 0.
  - Reserved op: ignored.
- MUL_RUN / DIV_RUN:
  - busy=1. Counter decrements each edge.
  - At the edge where counter==0: hi/lo <= staging, go to IDLE, busy=0.
  - busy is high for exactly N cycles after the accepting edge. New hi/lo are visible in the first cycle busy=0.
- start while busy: ignored entirely, including MTHI/MTLO. The hazard unit guarantees no issue while busy; the block must still never corrupt state on a violation.
- busy is a registered output. The hazard unit must treat (start & op<4) | busy as the stall condition.
- Multiply:
  - MULT: signed 32x32 to 64, {hi,lo}=a*b.
  - MULTU: unsigned 32x32 to 64.
- Divide:
  - lo=quotient, hi=remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero (b==0), DIV or DIVU: lo=32'hFFFF_FFFF, hi=a. Full DIV_CYCLES latency still applies.
  - Signed overflow (a=32'h8000_0000, b=32'hFFFF_FFFF, DIV): lo=32'h8000_0000, hi=0.
- Staging regs are computed from a/b/op at the accepting edge. Later changes to a/b do not affect the result.
- hi/lo change only at reset, at MTHI/MTLO in IDLE, or at run completion.

Decomposition:
- Shared package (mips_defs): MD_OP_* opcode constants (3-bit) and the md state encoding. The ID-stage decoder uses the same MD_OP_* constants.
- Sub-module md_arith (combinational): computes the 64-bit product or quotient/remainder from op/a/b, including the div-by-zero and overflow rules.
- md_unit holds the FSM, counter, staging regs and HI/LO.

Test Plan:
- MULT a=32'hFFFF_FFFD (-3), b=7, then idle: busy=1 for exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
- MULTU same operands: hi=32'h0000_0006, lo=32'hFFFF_FFEB after 5 cycles. DIVU a=7, b=2: lo=3, hi=1 after 10 busy cycles.
- DIV a=-7, b=2: lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIV a=32'h8000_0000, b=-1: lo=32'h8000_0000, hi=0. DIV a=5, b=0: lo=32'hFFFF_FFFF, hi=5.
- MTHI a=32'h1234_5678, then MTLO a=32'h9ABC_DEF0 in IDLE: busy stays 0; hi/lo update at the next edge. hilo_out follows rd_hi combinationally.
- Start MULT; on cycle 2 of busy, pulse start with op=MTLO a=32'hDEAD_BEEF and with op=DIV: both ignored, lo ends at the MULT result, busy still falls after exactly 5 cycles.
- Start DIV, assert reset=0 on cycle 4 (async, between edges): busy, hi, lo go to 0 immediately. After release, unit is in IDLE and a new MULTU 3x3 gives lo=9, hi=0.

Source files
------------

// File: rtl/mips_defs.sv
// mips_defs: shared mult/div opcode constants and md unit state encoding.
package mips_defs;

    localparam logic [2:0] MD_OP_MULT  = 3'd0;
    localparam logic [2:0] MD_OP_MULTU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_MTHI  = 3'd4;
    localparam logic [2:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL_RUN,
        MD_DIV_RUN
    } md_state_t;

    function automatic logic is_mul(input logic [2:0] op);
        return op == MD_OP_MULT || op == MD_OP_MULTU;
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op == MD_OP_DIV || op == MD_OP_DIVU;
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit product or {remainder, quotient} for the md unit.
module md_arith
    import mips_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res
);

    logic [63:0] ps, pu;
    logic [31:0] ma, mb, uq, ur, q, r;
    logic        sgn;

    // Signed divide runs on magnitudes; the overflow case falls out naturally.
    always_comb begin
        ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu  = {32'b0, a} * {32'b0, b};
        sgn = op == MD_OP_DIV;
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        uq  = ma / mb;
        ur  = ma % mb;
        q   = (sgn && (a[31] ^ b[31])) ? -uq : uq;
        r   = (sgn && a[31]) ? -ur : ur;
        res = op == MD_OP_MULT  ? ps :
              op == MD_OP_MULTU ? pu :
              b == 32'b0        ? {a, 32'hFFFF_FFFF} : {r, q};
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS32 multiply/divide unit holding HI/LO.
module md_unit
    import mips_defs::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hilo_out
);

    localparam int CW = $clog2(DIV_CYCLES > MUL_CYCLES ? DIV_CYCLES : MUL_CYCLES) + 1;

    md_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [63:0] stage, res;
    logic        idle, acc, done;

    md_arith u_arith (.op(op), .a(a), .b(b), .res(res));

    assign idle     = state == MD_IDLE;
    assign acc      = start && idle;
    assign done     = !idle && cnt == '0;
    assign busy     = !idle;
    assign hilo_out = rd_hi ? hi : lo;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (acc && is_mul(op)) begin
            state_n = MD_MUL_RUN;
            cnt_n   = CW'(MUL_CYCLES - 1);
        end else if (acc && is_div(op)) begin
            state_n = MD_DIV_RUN;
            cnt_n   = CW'(DIV_CYCLES - 1);
        end else if (done) begin
            state_n = MD_IDLE;
        end else if (!idle) begin
            cnt_n = cnt - 1'b1;
        end
    end

    // Starts while busy never reach hi/lo or staging because acc requires idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            stage <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (acc && (is_mul(op) || is_div(op))) stage <= res;
            if (acc && op == MD_OP_MTHI) hi <= a;
            if (acc && op == MD_OP_MTLO) lo <= a;
            if (done) {hi, lo} <= stage;
        end
    end

endmodule
